multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 104 ++++++++++
 rtl/multi_cycle_ctrl_if.sv | 36 +++
 rtl/alu_op_decoder.sv | 27 ++
 rtl/multi_cycle_ctrl.sv | 120 ++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, ALU/PC/RegDst codes,
// state encoding and the control-word payload.
package multi_cycle_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'b010000;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'b010001;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPCODE_W-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPCODE_W-1:0] OP_SLTU = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_SLTI = 6'b100111;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b110000;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b110001;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'b110101;
    localparam logic [OPCODE_W-1:0] OP_BLTZ = 6'b110110;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b111000;
    localparam logic [OPCODE_W-1:0] OP_JR   = 6'b111001;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 6'b111010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 3'b110;

    localparam logic [SEL_W-1:0] PC_NEXT   = 2'b00;
    localparam logic [SEL_W-1:0] PC_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] PC_JR     = 2'b10;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'b11;

    localparam logic [SEL_W-1:0] RD_RA = 2'b00;
    localparam logic [SEL_W-1:0] RD_RT = 2'b01;
    localparam logic [SEL_W-1:0] RD_RD = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        ST_IF     = 4'b0000,
        ST_ID     = 4'b0001,
        ST_EXE_LS = 4'b0010,
        ST_MEM    = 4'b0011,
        ST_WB_LD  = 4'b0100,
        ST_EXE_BR = 4'b0101,
        ST_EXE_AL = 4'b0110,
        ST_WB_AL  = 4'b0111,
        ST_HALT   = 4'b1000
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_BRANCH,
        CL_LDST,
        CL_JUMP,
        CL_HALT,
        CL_NOP
    } op_class_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic               alu_src_b;
        logic               ext_sel;
    } alu_ctrl_t;

    typedef struct packed {
        logic               pc_wre;
        logic               ir_wre;
        logic               alu_src_a;
        logic               alu_src_b;
        logic               reg_wre;
        logic               wr_reg_d_src;
        logic               db_data_src;
        logic               m_rd;
        logic               m_wr;
        logic               ext_sel;
        logic               halted;
        logic [SEL_W-1:0]   reg_dst;
        logic [SEL_W-1:0]   pc_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // Groups opcodes by the execution path they take after decode.
    function automatic op_class_e op_class(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
            OP_ORI, OP_SLL, OP_SLTU, OP_SLTI:  return CL_ALU;
            OP_BEQ, OP_BNE, OP_BLTZ:           return CL_BRANCH;
            OP_SW, OP_LW:                      return CL_LDST;
            OP_J, OP_JR, OP_JAL:               return CL_JUMP;
            OP_HALT:                           return CL_HALT;
            default:                           return CL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Opcode/flag inputs and control-word outputs between the controller and the datapath.
interface multi_cycle_ctrl_if;

    logic [multi_cycle_ctrl_pkg::OPCODE_W-1:0] opcode;
    logic                                      zero;
    logic                                      sign;

    logic                                      PCWre;
    logic                                      IRWre;
    logic                                      ALUSrcA;
    logic                                      ALUSrcB;
    logic                                      RegWre;
    logic                                      WrRegDSrc;
    logic                                      DBDataSrc;
    logic                                      mRD;
    logic                                      mWR;
    logic                                      ExtSel;
    logic                                      halted;
    logic [multi_cycle_ctrl_pkg::SEL_W-1:0]    RegDst;
    logic [multi_cycle_ctrl_pkg::SEL_W-1:0]    PCSrc;
    logic [multi_cycle_ctrl_pkg::ALUOP_W-1:0]  ALUOp;
    logic [multi_cycle_ctrl_pkg::STATE_W-1:0]  state;

    modport master (
        output opcode, zero, sign,
        input  PCWre, IRWre, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc,
               mRD, mWR, ExtSel, halted, RegDst, PCSrc, ALUOp, state
    );

    modport slave (
        input  opcode, zero, sign,
        output PCWre, IRWre, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc,
               mRD, mWR, ExtSel, halted, RegDst, PCSrc, ALUOp, state
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational opcode decode of the ALU operation, operand sources and immediate extension.
module alu_op_decoder
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output alu_ctrl_t           o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = '0;
        o_alu_ctrl.alu_op = ALU_ADD;
        case (i_opcode)
            OP_SUB, OP_BEQ, OP_BNE: o_alu_ctrl.alu_op = ALU_SUB;
            OP_SLTI, OP_BLTZ:       o_alu_ctrl.alu_op = ALU_SLT;
            OP_SLTU:                o_alu_ctrl.alu_op = ALU_SLTU;
            OP_OR, OP_ORI:          o_alu_ctrl.alu_op = ALU_OR;
            OP_AND:                 o_alu_ctrl.alu_op = ALU_AND;
            OP_SLL:                 o_alu_ctrl.alu_op = ALU_SLL;
            default:                o_alu_ctrl.alu_op = ALU_ADD;
        endcase
        // Shift amount comes from the shamt field rather than rs.
        o_alu_ctrl.alu_src_a = (i_opcode == OP_SLL);
        o_alu_ctrl.alu_src_b = (i_opcode inside {OP_ADDI, OP_ORI, OP_SLTI, OP_SW, OP_LW});
        o_alu_ctrl.ext_sel   = (i_opcode != OP_ORI);
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: IF/ID/EXE/MEM/WB sequencing with control outputs
// decoded combinationally from the current state and opcode.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_n,
    multi_cycle_ctrl_if.slave bus
);

    state_e    r_state;
    state_e    w_next_state;
    op_class_e w_class;
    alu_ctrl_t w_alu;
    ctrl_t     w_ctrl;
    logic      w_taken;
    logic      w_last;

    assign w_class = op_class(bus.opcode);

    alu_op_decoder u_alu_op_decoder (
        .i_opcode   (bus.opcode),
        .o_alu_ctrl (w_alu)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_IF;
        case (r_state)
            ST_IF: w_next_state = ST_ID;
            ST_ID: begin
                case (w_class)
                    CL_ALU:    w_next_state = ST_EXE_AL;
                    CL_BRANCH: w_next_state = ST_EXE_BR;
                    CL_LDST:   w_next_state = ST_EXE_LS;
                    CL_HALT:   w_next_state = ST_HALT;
                    default:   w_next_state = ST_IF;
                endcase
            end
            ST_EXE_AL: w_next_state = ST_WB_AL;
            ST_EXE_LS: w_next_state = ST_MEM;
            ST_MEM:    w_next_state = (bus.opcode == OP_LW) ? ST_WB_LD : ST_IF;
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_IF;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (bus.opcode)
            OP_BEQ:  w_taken = bus.zero;
            OP_BNE:  w_taken = !bus.zero;
            OP_BLTZ: w_taken = bus.sign;
            default: w_taken = 1'b0;
        endcase
    end

    // Cycle in which the instruction retires and the PC advances.
    assign w_last = (r_state == ST_WB_AL) || (r_state == ST_EXE_BR) || (r_state == ST_WB_LD)
                 || (r_state == ST_MEM && bus.opcode == OP_SW)
                 || (r_state == ST_ID && (w_class == CL_JUMP || w_class == CL_NOP));

    // Everything is forced low while reset is held so no partial write escapes.
    always_comb begin
        w_ctrl = '0;
        if (RST_n) begin
            w_ctrl.ir_wre       = (r_state == ST_IF);
            w_ctrl.pc_wre       = w_last;
            w_ctrl.reg_wre      = (r_state == ST_WB_AL) || (r_state == ST_WB_LD)
                               || (r_state == ST_ID && bus.opcode == OP_JAL);
            w_ctrl.m_wr         = (r_state == ST_MEM) && (bus.opcode == OP_SW);
            w_ctrl.m_rd         = (r_state == ST_MEM) && (bus.opcode == OP_LW);
            w_ctrl.db_data_src  = (r_state == ST_WB_LD);
            w_ctrl.halted       = (r_state == ST_HALT);
            w_ctrl.wr_reg_d_src = (bus.opcode != OP_JAL);
            w_ctrl.alu_op       = w_alu.alu_op;
            w_ctrl.alu_src_a    = w_alu.alu_src_a;
            w_ctrl.alu_src_b    = w_alu.alu_src_b;
            w_ctrl.ext_sel      = w_alu.ext_sel;
            case (bus.opcode)
                OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLTU: w_ctrl.reg_dst = RD_RD;
                OP_ADDI, OP_ORI, OP_SLTI, OP_LW:                w_ctrl.reg_dst = RD_RT;
                default:                                        w_ctrl.reg_dst = RD_RA;
            endcase
            if (bus.opcode == OP_JR) begin
                w_ctrl.pc_src = PC_JR;
            end else if (bus.opcode == OP_J || bus.opcode == OP_JAL) begin
                w_ctrl.pc_src = PC_JUMP;
            end else if (r_state == ST_EXE_BR && w_taken) begin
                w_ctrl.pc_src = PC_BRANCH;
            end else begin
                w_ctrl.pc_src = PC_NEXT;
            end
        end
    end

    assign bus.PCWre     = w_ctrl.pc_wre;
    assign bus.IRWre     = w_ctrl.ir_wre;
    assign bus.ALUSrcA   = w_ctrl.alu_src_a;
    assign bus.ALUSrcB   = w_ctrl.alu_src_b;
    assign bus.RegWre    = w_ctrl.reg_wre;
    assign bus.WrRegDSrc = w_ctrl.wr_reg_d_src;
    assign bus.DBDataSrc = w_ctrl.db_data_src;
    assign bus.mRD       = w_ctrl.m_rd;
    assign bus.mWR       = w_ctrl.m_wr;
    assign bus.ExtSel    = w_ctrl.ext_sel;
    assign bus.halted    = w_ctrl.halted;
    assign bus.RegDst    = w_ctrl.reg_dst;
    assign bus.PCSrc     = w_ctrl.pc_src;
    assign bus.ALUOp     = w_ctrl.alu_op;
    assign bus.state     = STATE_W'(r_state);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle comparison against an instruction-level
// model plus hand-computed literal expectations at key points.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLTU = 6'b100110, OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101, OP_BLTZ = 6'b110110, OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001, OP_JAL  = 6'b111010, OP_HALT = 6'b111111;
    localparam logic [5:0] OP_UNDEF = 6'b000111;

    localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXE_LS = 4'd2, S_MEM = 4'd3;
    localparam logic [3:0] S_WB_LD = 4'd4, S_EXE_BR = 4'd5, S_EXE_AL = 4'd6, S_WB_AL = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwre;
        logic       irwre;
        logic       srca;
        logic       srcb;
        logic       regwre;
        logic       wrregdsrc;
        logic       dbdatasrc;
        logic       mrd;
        logic       mwr;
        logic       extsel;
        logic       halted;
        logic [1:0] regdst;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
    } obs_t;

    logic CLK;
    logic RST_n;
    int   checks;
    int   errors;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl u_dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t dut_obs();
        obs_t o;
        o.st        = bus.state;
        o.pcwre     = bus.PCWre;
        o.irwre     = bus.IRWre;
        o.srca      = bus.ALUSrcA;
        o.srcb      = bus.ALUSrcB;
        o.regwre    = bus.RegWre;
        o.wrregdsrc = bus.WrRegDSrc;
        o.dbdatasrc = bus.DBDataSrc;
        o.mrd       = bus.mRD;
        o.mwr       = bus.mWR;
        o.extsel    = bus.ExtSel;
        o.halted    = bus.halted;
        o.regdst    = bus.RegDst;
        o.pcsrc     = bus.PCSrc;
        o.aluop     = bus.ALUOp;
        return o;
    endfunction

    // Instruction-level model: expected outputs for cycle idx of an instruction (idx 0 = IF).
    function automatic obs_t model(input logic [5:0] op, input int idx, input logic z, input logic s);
        obs_t e;
        bit   is_al, is_br, is_halt, is_lw, is_sw, taken;
        int   ncyc;
        e       = '0;
        is_al   = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLTU, OP_SLTI};
        is_br   = op inside {OP_BEQ, OP_BNE, OP_BLTZ};
        is_halt = (op == OP_HALT);
        is_lw   = (op == OP_LW);
        is_sw   = (op == OP_SW);
        ncyc    = is_al ? 4 : is_br ? 3 : is_sw ? 4 : is_lw ? 5 : 2;
        taken   = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s);

        if (idx == 0)      e.st = S_IF;
        else if (idx == 1) e.st = S_ID;
        else if (is_halt)  e.st = S_HALT;
        else if (is_al)    e.st = (idx == 2) ? S_EXE_AL : S_WB_AL;
        else if (is_br)    e.st = S_EXE_BR;
        else               e.st = (idx == 2) ? S_EXE_LS : (idx == 3) ? S_MEM : S_WB_LD;

        e.irwre     = (idx == 0);
        e.pcwre     = !is_halt && (idx == ncyc - 1);
        e.regwre    = ((is_al || is_lw) && idx == ncyc - 1) || (op == OP_JAL && idx == 1);
        e.mwr       = is_sw && idx == 3;
        e.mrd       = is_lw && idx == 3;
        e.dbdatasrc = is_lw && idx == 4;
        e.halted    = is_halt && idx >= 2;
        e.wrregdsrc = (op != OP_JAL);
        e.srca      = (op == OP_SLL);
        e.srcb      = op inside {OP_ADDI, OP_ORI, OP_SLTI, OP_SW, OP_LW};
        e.extsel    = (op != OP_ORI);

        if (op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLTU}) e.regdst = 2'b10;
        else if (op inside {OP_ADDI, OP_ORI, OP_SLTI, OP_LW})          e.regdst = 2'b01;
        else                                                           e.regdst = 2'b00;

        if (op == OP_JR)                        e.pcsrc = 2'b10;
        else if (op == OP_J || op == OP_JAL)    e.pcsrc = 2'b11;
        else if (is_br && idx == 2 && taken)    e.pcsrc = 2'b01;
        else                                    e.pcsrc = 2'b00;

        if (op inside {OP_SUB, OP_BEQ, OP_BNE})   e.aluop = 3'b001;
        else if (op inside {OP_SLTI, OP_BLTZ})    e.aluop = 3'b110;
        else if (op == OP_SLTU)                   e.aluop = 3'b101;
        else if (op inside {OP_OR, OP_ORI})       e.aluop = 3'b011;
        else if (op == OP_AND)                    e.aluop = 3'b100;
        else if (op == OP_SLL)                    e.aluop = 3'b010;
        else                                      e.aluop = 3'b000;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Checks cycles i0..i1-1 of one instruction on the falling edge; returns #1 after the next rising edge.
    task automatic run_seg(input string nm, input logic [5:0] op, input logic z, input logic s,
                           input int i0, input int i1);
        obs_t exp_o;
        bus.opcode = op;
        bus.zero   = z;
        bus.sign   = s;
        for (int idx = i0; idx < i1; idx++) begin
            exp_o = model(op, idx, z, s);
            @(negedge CLK);
            chk($sformatf("%s c%0d", nm, idx), 32'(dut_obs()), 32'(exp_o));
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_full(input string nm, input logic [5:0] op, input logic z, input logic s);
        int n;
        n = (op inside {OP_BEQ, OP_BNE, OP_BLTZ}) ? 3 :
            (op == OP_LW) ? 5 :
            (op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLTU, OP_SLTI, OP_SW}) ? 4 : 2;
        run_seg(nm, op, z, s, 0, n);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        RST_n      = 1'b0;
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset outputs", 32'(dut_obs()), 32'h0);
        chk("reset irwre", 32'(bus.IRWre), 32'h0);
        RST_n = 1'b1;

        // add with flags set: flags must not leak into non-branch outputs
        run_seg("add", OP_ADD, 1'b1, 1'b1, 0, 3);
        chk("add wb state", 32'(bus.state), 32'h7);
        chk("add wb regwre", 32'(bus.RegWre), 32'h1);
        chk("add wb regdst", 32'(bus.RegDst), 32'h2);
        chk("add wb aluop", 32'(bus.ALUOp), 32'h0);
        run_seg("add", OP_ADD, 1'b1, 1'b1, 3, 4);
        chk("add back to IF", 32'(bus.state), 32'h0);

        run_full("sub",  OP_SUB,  1'b0, 1'b0);
        run_full("addi", OP_ADDI, 1'b0, 1'b0);
        run_full("or",   OP_OR,   1'b0, 1'b0);
        run_full("and",  OP_AND,  1'b0, 1'b0);
        run_full("ori",  OP_ORI,  1'b0, 1'b0);
        run_full("sll",  OP_SLL,  1'b0, 1'b0);
        run_full("sltu", OP_SLTU, 1'b0, 1'b1);
        run_full("slti", OP_SLTI, 1'b1, 1'b0);

        run_seg("lw", OP_LW, 1'b0, 1'b0, 0, 3);
        chk("lw mem mrd", 32'(bus.mRD), 32'h1);
        chk("lw mem pcwre", 32'(bus.PCWre), 32'h0);
        run_seg("lw", OP_LW, 1'b0, 1'b0, 3, 4);
        chk("lw wb state", 32'(bus.state), 32'h4);
        chk("lw wb dbdatasrc", 32'(bus.DBDataSrc), 32'h1);
        chk("lw wb regwre", 32'(bus.RegWre), 32'h1);
        chk("lw wb pcwre", 32'(bus.PCWre), 32'h1);
        run_seg("lw", OP_LW, 1'b0, 1'b0, 4, 5);

        run_full("sw", OP_SW, 1'b0, 1'b0);

        run_seg("beq z1", OP_BEQ, 1'b1, 1'b0, 0, 2);
        chk("beq taken pcsrc", 32'(bus.PCSrc), 32'h1);
        run_seg("beq z1", OP_BEQ, 1'b1, 1'b0, 2, 3);
        run_seg("beq z0", OP_BEQ, 1'b0, 1'b0, 0, 2);
        chk("beq not taken pcsrc", 32'(bus.PCSrc), 32'h0);
        run_seg("beq z0", OP_BEQ, 1'b0, 1'b0, 2, 3);
        run_full("bne z0", OP_BNE, 1'b0, 1'b0);
        run_full("bne z1", OP_BNE, 1'b1, 1'b0);
        run_seg("bltz s1", OP_BLTZ, 1'b0, 1'b1, 0, 2);
        chk("bltz taken pcsrc", 32'(bus.PCSrc), 32'h1);
        run_seg("bltz s1", OP_BLTZ, 1'b0, 1'b1, 2, 3);
        run_full("bltz s0", OP_BLTZ, 1'b1, 1'b0);

        run_full("j",  OP_J,  1'b0, 1'b0);
        run_full("jr", OP_JR, 1'b0, 1'b0);
        run_seg("jal", OP_JAL, 1'b0, 1'b0, 0, 1);
        chk("jal id regwre", 32'(bus.RegWre), 32'h1);
        chk("jal id regdst", 32'(bus.RegDst), 32'h0);
        chk("jal id pcsrc", 32'(bus.PCSrc), 32'h3);
        chk("jal id pcwre", 32'(bus.PCWre), 32'h1);
        run_seg("jal", OP_JAL, 1'b0, 1'b0, 1, 2);
        chk("jal next IF", 32'(bus.state), 32'h0);

        run_seg("undef", OP_UNDEF, 1'b0, 1'b0, 0, 1);
        chk("undef id pcsrc", 32'(bus.PCSrc), 32'h0);
        chk("undef id pcwre", 32'(bus.PCWre), 32'h1);
        chk("undef id regwre", 32'(bus.RegWre), 32'h0);
        chk("undef id mwr", 32'(bus.mWR), 32'h0);
        run_seg("undef", OP_UNDEF, 1'b0, 1'b0, 1, 2);

        run_seg("halt", OP_HALT, 1'b0, 1'b0, 0, 12);
        chk("halt state", 32'(bus.state), 32'h8);
        chk("halt halted", 32'(bus.halted), 32'h1);
        #3;
        RST_n = 1'b0;
        #1;
        chk("halt reset state", 32'(bus.state), 32'h0);
        chk("halt reset outputs", 32'(dut_obs()), 32'h0);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;

        run_seg("sw", OP_SW, 1'b0, 1'b0, 0, 3);
        chk("sw mem state", 32'(bus.state), 32'h3);
        chk("sw mem mwr", 32'(bus.mWR), 32'h1);
        #3;
        RST_n = 1'b0;
        #1;
        chk("sw reset state", 32'(bus.state), 32'h0);
        chk("sw reset mwr", 32'(bus.mWR), 32'h0);
        chk("sw reset pcwre", 32'(bus.PCWre), 32'h0);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;

        run_full("add after reset", OP_ADD, 1'b0, 1'b0);
        run_full("lw after reset", OP_LW, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
